byte_serializer: RTL and testbench
==================================

# byte_serializer

Converts the 8-bit byte stream produced by the width converter (`to8bit`) into a 1-bit serial stream for the physical lane, MSB first by default. It runs on the bit clock (8× the byte rate) and holds a one-byte shift register. After every reset it emits a fixed run of idle/sync bytes before the lane is declared up. When upstream has no byte ready, it inserts an idle byte instead.

## Interface
- `IDLE_BYTE`, 8'hBC: byte sent during sync and on underrun.
- `SYNC_BYTES`, 4: number of idle bytes sent after reset before entering ACTIVE; legal range 1–255.
- `MSB_FIRST`, 1: 1 = bit 7 first; 0 = bit 0 first.
- `clk` input 1: bit clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enb` input 1: clock enable; when low, all state holds.
- `dataIn` input 8: byte from the width converter.
- `validIn` input 1: `dataIn` holds a byte to send.
- `serialOut` output 1: serial bit, registered.
- `byteStart` output 1: high during the first bit of each byte.
- `dataAck` output 1: one-cycle pulse; the byte presented at the last load edge was consumed.
- `linkUp` output 1: high once sync is complete (state ACTIVE).

## Operation
- Internal registers:
  - `bitCnt[2:0]`
  - `sreg[7:0]`, the shift register
  - `syncCnt[7:0]`
  - `state` ∈ {SYNC, ACTIVE}
- Reset (`rst`=1 at an edge; dominates `enb`):
  - `bitCnt`=7, `sreg`=0, `syncCnt`=0, `state`=SYNC.
  - Outputs `serialOut`=0, `byteStart`=0, `dataAck`=0, `linkUp`=0.
- A **load edge** is an enabled edge with `bitCnt`==7. At a load edge:
  - `bitCnt`←0.
  - `sreg` is loaded with the next byte, already bit-reordered so that `sreg[7]` is the first bit out.
  - `serialOut`←first bit of that byte; `byteStart`←1.
- Other enabled edges:
  - `bitCnt`++ and `sreg` shifts left by 1.
  - `serialOut`←next bit; `byteStart`←0.
- Next-byte selection at a load edge:
  - SYNC: load `IDLE_BYTE` and `syncCnt`++. If `syncCnt`==`SYNC_BYTES`-1, set `state`←ACTIVE. `dataAck`←0.
  - ACTIVE with `validIn`=1: load `dataIn` and set `dataAck`←1.
  - ACTIVE with `validIn`=0: load `IDLE_BYTE` and set `dataAck`←0 (underrun).
- `dataAck` is cleared on every enabled non-load edge, and also on any edge where `enb`=0.
- Handshake with upstream:
  - Upstream holds `dataIn`/`validIn` stable until it sees `dataAck`=1.
  - The cycle after `dataAck`, upstream may present the next byte or drop `validIn`.
- `linkUp` = registered (`state`==ACTIVE).
- `enb`=0:
  - `bitCnt`, `sreg`, `syncCnt`, `state`, `serialOut`, `byteStart` and `linkUp` hold.
  - `dataAck`=0.
  - The bit in flight is stretched.

## Timing
- Input sampling: `dataIn` and `validIn` are sampled only at load edges; they are ignored at all other edges.
- Load latency: the first bit of a loaded byte is on `serialOut` immediately after its load edge. Its last bit is shown after the 7th following enabled edge.
- Byte throughput: one byte per 8 enabled clocks. Output has no gap between bytes.
- Sync sequence after reset release (with `enb`=1 throughout):
  - Load edges fall on enabled edges 1, 9, 17, 25, …
  - With `SYNC_BYTES`=4, edges 1–25 load `IDLE_BYTE`.
  - `linkUp` rises after edge 26.
  - The first user byte can be accepted at edge 33.
- Reset mid-byte: the current byte is abandoned, no further bits are shifted, and the full sync sequence restarts.
- `enb` low exactly on a would-be load edge: no load happens and `validIn` is not sampled. The load occurs on the next enabled edge.
- `rst` and `enb`=0 asserted together: reset wins.
- `syncCnt` stops updating in ACTIVE, so it never wraps.

## Test plan
- **Reset/sync:** `rst`=1 for 4 clocks, then `enb`=1, `validIn`=0, defaults.
  - Expect all outputs 0 during reset.
  - Expect 32 bits of 10111100 ×4, with `byteStart` at bits 0, 8, 16, 24.
  - Expect `linkUp`=1 from edge 26.
- **Data, MSB first:** in ACTIVE, `validIn`=1 with `dataIn`=8'h9A.
  - Expect `serialOut`=1,0,0,1,1,0,1,0.
  - Expect `dataAck` pulse on the same cycle as `byteStart`.
- **Back-to-back bytes:** 8'hFF, 8'h00, 8'hF0, 8'h0F, 8'h6D, 8'hAD via the handshake.
  - Expect 48 contiguous bits matching those bytes.
  - Expect exactly 6 `dataAck` pulses.
- **Underrun:** drop `validIn` for one byte slot between 8'h43 and 8'h3F.
  - Expect 01000011, 10111100, 00111111.
  - Expect no `dataAck` pulse for the idle slot.
- **`enb` stall:** pull `enb` low for 5 clocks mid-byte (after bit 3 of 8'h95).
  - Expect `serialOut` to hold bit 3, `dataAck`=0, and `bitCnt` frozen.
  - Expect the byte to resume correctly after `enb` returns high.
- **Reset mid-operation and `MSB_FIRST`=0:**
  - Pulse `rst` during bit 5 of 8'h54. Expect `linkUp`→0 and the 4-byte sync to restart.
  - With `MSB_FIRST`=0, send 8'h03. Expect 1,1,0,0,0,0,0,0.

Source files
------------

// File: rtl/byte_serializer.sv
// Byte-to-bit serializer for the physical lane: sends a fixed idle/sync run after reset,
// then shifts out upstream bytes, and fills any slot that upstream leaves empty with an idle byte.
module byte_serializer #(
    parameter logic [7:0]  IDLE_BYTE  = 8'hBC,
    parameter int unsigned SYNC_BYTES = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic [7:0] dataIn,
    input  logic       validIn,
    output logic       serialOut,
    output logic       byteStart,
    output logic       dataAck,
    output logic       linkUp
);
    typedef enum logic {ST_SYNC = 1'b0, ST_ACTIVE = 1'b1} state_t;

    localparam logic [7:0] LAST_SYNC = 8'(SYNC_BYTES - 1);

    logic [2:0] r_bit_cnt;
    logic [7:0] r_sreg;
    logic [7:0] r_sync_cnt;
    state_t     r_state;

    logic       w_load;
    logic       w_take_data;
    logic [7:0] w_next_byte;
    logic [7:0] w_load_byte;

    assign w_load      = (r_bit_cnt == 3'd7);
    assign w_take_data = (r_state == ST_ACTIVE) && validIn;
    assign w_next_byte = w_take_data ? dataIn : IDLE_BYTE;

    // Bit-reorder at load time so the first bit on the wire always sits in sreg[7].
    always_comb begin
        w_load_byte = w_next_byte;
        if (!MSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                w_load_byte[i] = w_next_byte[7-i];
            end
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples pre-edge values; blocking here would let sreg feed serialOut a cycle early.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= 3'd7;
            r_sreg     <= 8'd0;
            r_sync_cnt <= 8'd0;
            r_state    <= ST_SYNC;
            serialOut  <= 1'b0;
            byteStart  <= 1'b0;
            dataAck    <= 1'b0;
            linkUp     <= 1'b0;
        end else if (enb) begin
            linkUp <= (r_state == ST_ACTIVE);
            if (w_load) begin
                r_bit_cnt <= 3'd0;
                r_sreg    <= w_load_byte;
                serialOut <= w_load_byte[7];
                byteStart <= 1'b1;
                dataAck   <= w_take_data;
                // syncCnt only advances during SYNC, so it cannot wrap once ACTIVE.
                if (r_state == ST_SYNC) begin
                    r_sync_cnt <= r_sync_cnt + 8'd1;
                    if (r_sync_cnt == LAST_SYNC) begin
                        r_state <= ST_ACTIVE;
                    end
                end
            end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_sreg    <= {r_sreg[6:0], 1'b0};
                serialOut <= r_sreg[6];
                byteStart <= 1'b0;
                dataAck   <= 1'b0;
            end
        end else begin
            // Stalled: the bit in flight is stretched, only the ack pulse is cleared.
            dataAck <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: MSB-first and LSB-first instances share stimulus,
// and every clock is compared against a slot-level model of the serial lane.
module tb_byte_serializer;
    localparam logic [7:0] IDLE = 8'hBC;
    localparam int         SYNC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       validIn;
    logic [7:0] dataIn;
    logic       so_m, bs_m, ack_m, lu_m;
    logic       so_l, bs_l, ack_l, lu_l;

    int checks = 0;
    int errors = 0;

    // Model: n counts enabled edges since reset; byte slot = (n-1)/8, bit = (n-1)%8.
    int         n;
    int         first_lu_n;
    int         ack_cnt;
    logic [7:0] cur;
    logic       e_so_m, e_so_l, e_bs, e_ack, e_lu;

    // Bytes reassembled from each lane, plus whether their load edge carried dataAck.
    logic [7:0] rx_m, rx_l;
    logic       rx_ack;
    logic [7:0] bytes_m[$];
    logic [7:0] bytes_l[$];
    bit         acked[$];

    byte_serializer #(.IDLE_BYTE(IDLE), .SYNC_BYTES(SYNC), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .enb(enb), .dataIn(dataIn), .validIn(validIn),
        .serialOut(so_m), .byteStart(bs_m), .dataAck(ack_m), .linkUp(lu_m)
    );

    byte_serializer #(.IDLE_BYTE(IDLE), .SYNC_BYTES(SYNC), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .enb(enb), .dataIn(dataIn), .validIn(validIn),
        .serialOut(so_l), .byteStart(bs_l), .dataAck(ack_l), .linkUp(lu_l)
    );

    always #5 clk = ~clk;

    task automatic tick();
        int bi;
        int slot;
        logic [7:0] got;
        logic [7:0] want;
        @(posedge clk);
        bi = 0;
        if (rst) begin
            n = 0; first_lu_n = 0;
            e_so_m = 1'b0; e_so_l = 1'b0; e_bs = 1'b0; e_ack = 1'b0; e_lu = 1'b0;
        end else if (!enb) begin
            e_ack = 1'b0;
        end else begin
            n++;
            bi   = (n - 1) % 8;
            slot = (n - 1) / 8;
            if (bi == 0) begin
                if (slot >= SYNC && validIn) begin
                    cur = dataIn; e_ack = 1'b1;
                end else begin
                    cur = IDLE; e_ack = 1'b0;
                end
            end else begin
                e_ack = 1'b0;
            end
            e_bs   = (bi == 0);
            e_so_m = cur[7-bi];
            e_so_l = cur[bi];
            e_lu   = (n >= 8 * (SYNC - 1) + 2);
        end
        #1;
        got  = {so_m, so_l, bs_m, bs_l, ack_m, ack_l, lu_m, lu_l};
        want = {e_so_m, e_so_l, e_bs, e_bs, e_ack, e_ack, e_lu, e_lu};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t n=%0d {so_m,so_l,bs_m,bs_l,ack_m,ack_l,lu_m,lu_l} got=%b want=%b",
                     $time, n, got, want);
        end
        if (!rst && enb) begin
            rx_m = {rx_m[6:0], so_m};
            rx_l = {so_l, rx_l[7:1]};
            if (bi == 0) rx_ack = ack_m;
            if (ack_m) ack_cnt++;
            if (lu_m && first_lu_n == 0) first_lu_n = n;
            if (bi == 7) begin
                bytes_m.push_back(rx_m);
                bytes_l.push_back(rx_l);
                acked.push_back(rx_ack);
            end
        end
    endtask

    task automatic clear_rx();
        bytes_m.delete();
        bytes_l.delete();
        acked.delete();
        ack_cnt = 0;
    endtask

    task automatic idle(input int cycles);
        validIn = 1'b0;
        repeat (cycles) tick();
    endtask

    // Present a byte and hold it until dataAck, optionally with random enable stalls.
    task automatic send_one(input logic [7:0] b, input bit rand_enb);
        bit got_ack = 1'b0;
        validIn = 1'b1;
        dataIn  = b;
        for (int k = 0; k < 200 && !got_ack; k++) begin
            if (rand_enb) enb = ($urandom_range(0, 3) != 0);
            tick();
            if (ack_m) got_ack = 1'b1;
        end
        enb = 1'b1;
        checks++;
        if (!got_ack) begin
            errors++;
            $display("FAIL handshake_%02h: dataAck got=0 want=1 within 200 clocks", b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enb = 1'b0; validIn = 1'b0; dataIn = 8'h00;
        repeat (4) tick();
        checks++;
        if ({so_m, bs_m, ack_m, lu_m, so_l, bs_l, ack_l, lu_l} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {so_m, bs_m, ack_m, lu_m, so_l, bs_l, ack_l, lu_l});
        end
        rst = 1'b0; enb = 1'b1;
        clear_rx();
        repeat (32) tick();
        checks++;
        if (bytes_m.size() != SYNC) begin
            errors++;
            $display("FAIL sync_count got=%0d want=%0d", bytes_m.size(), SYNC);
        end
        for (int i = 0; i < bytes_m.size(); i++) begin
            checks++;
            if (bytes_m[i] !== IDLE || bytes_l[i] !== IDLE || acked[i]) begin
                errors++;
                $display("FAIL sync_byte%0d got=%02h/%02h ack=%0d want=%02h ack=0",
                         i, bytes_m[i], bytes_l[i], acked[i], IDLE);
            end
        end
        checks++;
        if (first_lu_n != 26) begin
            errors++;
            $display("FAIL linkup_edge got=%0d want=26", first_lu_n);
        end
    endtask

    task automatic test_msb_data();
        clear_rx();
        send_one(8'h9A, 1'b0);
        checks++;
        if (bs_m !== 1'b1) begin
            errors++;
            $display("FAIL ack_with_bytestart byteStart got=%b want=1", bs_m);
        end
        idle(7);
        checks++;
        if (bytes_m.size() == 0 || bytes_m[$] !== 8'h9A || !acked[$]) begin
            errors++;
            $display("FAIL data_9a got=%02h want=9a", bytes_m.size() ? bytes_m[$] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6];
        int first;
        seq = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 8'h6D, 8'hAD};
        clear_rx();
        foreach (seq[i]) send_one(seq[i], 1'b0);
        idle(7);
        checks++;
        if (ack_cnt != 6) begin
            errors++;
            $display("FAIL b2b_ack_count got=%0d want=6", ack_cnt);
        end
        first = -1;
        for (int i = 0; i < acked.size(); i++) if (acked[i] && first < 0) first = i;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (first < 0 || first + i >= bytes_m.size() || bytes_m[first+i] !== seq[i]
                || !acked[first+i]) begin
                errors++;
                $display("FAIL b2b_byte%0d got=%02h want=%02h", i,
                         (first >= 0 && first + i < bytes_m.size()) ? bytes_m[first+i] : 8'hxx, seq[i]);
            end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] exp_b [3];
        bit         exp_a [3];
        int first;
        exp_b = '{8'h43, IDLE, 8'h3F};
        exp_a = '{1'b1, 1'b0, 1'b1};
        clear_rx();
        send_one(8'h43, 1'b0);
        idle(8);
        send_one(8'h3F, 1'b0);
        idle(7);
        first = -1;
        for (int i = 0; i < acked.size(); i++) if (acked[i] && first < 0) first = i;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (first < 0 || first + i >= bytes_m.size() || bytes_m[first+i] !== exp_b[i]
                || acked[first+i] != exp_a[i]) begin
                errors++;
                $display("FAIL underrun_slot%0d got=%02h want=%02h ack_want=%0d", i,
                         (first >= 0 && first + i < bytes_m.size()) ? bytes_m[first+i] : 8'hxx,
                         exp_b[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_enb_stall();
        clear_rx();
        send_one(8'h95, 1'b0);
        validIn = 1'b0; dataIn = 8'h00;
        repeat (3) tick();
        enb = 1'b0;
        repeat (5) begin
            tick();
            checks++;
            if (so_m !== 1'b1 || ack_m !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold serialOut got=%b want=1 dataAck got=%b want=0", so_m, ack_m);
            end
        end
        enb = 1'b1;
        idle(4);
        checks++;
        if (bytes_m.size() == 0 || bytes_m[$] !== 8'h95) begin
            errors++;
            $display("FAIL stall_resume got=%02h want=95", bytes_m.size() ? bytes_m[$] : 8'hxx);
        end
        // Enable dropped exactly on the would-be load edge: no load, no sample.
        validIn = 1'b1; dataIn = 8'h5A; enb = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (ack_m !== 1'b0 || bs_m !== 1'b0) begin
                errors++;
                $display("FAIL stall_at_load dataAck got=%b byteStart got=%b want=0/0", ack_m, bs_m);
            end
        end
        enb = 1'b1;
        tick();
        checks++;
        if (ack_m !== 1'b1 || bs_m !== 1'b1) begin
            errors++;
            $display("FAIL load_after_stall dataAck got=%b byteStart got=%b want=1/1", ack_m, bs_m);
        end
        idle(7);
        checks++;
        if (bytes_m[$] !== 8'h5A) begin
            errors++;
            $display("FAIL load_after_stall_byte got=%02h want=5a", bytes_m[$]);
        end
    endtask

    task automatic test_reset_mid();
        send_one(8'h54, 1'b0);
        validIn = 1'b0;
        repeat (5) tick();
        rst = 1'b1; enb = 1'b0;
        tick();
        checks++;
        if (lu_m !== 1'b0 || so_m !== 1'b0 || bs_m !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset linkUp/serialOut/byteStart got=%b%b%b want=000", lu_m, so_m, bs_m);
        end
        rst = 1'b0; enb = 1'b1;
        clear_rx();
        repeat (32) tick();
        checks++;
        if (bytes_m.size() != SYNC || ack_cnt != 0) begin
            errors++;
            $display("FAIL resync got=%0d bytes %0d acks want=%0d bytes 0 acks",
                     bytes_m.size(), ack_cnt, SYNC);
        end
        for (int i = 0; i < bytes_m.size(); i++) begin
            checks++;
            if (bytes_m[i] !== IDLE) begin
                errors++;
                $display("FAIL resync_byte%0d got=%02h want=%02h", i, bytes_m[i], IDLE);
            end
        end
        checks++;
        if (first_lu_n != 26) begin
            errors++;
            $display("FAIL resync_linkup_edge got=%0d want=26", first_lu_n);
        end
    endtask

    task automatic test_lsb_first();
        clear_rx();
        send_one(8'h03, 1'b0);
        idle(7);
        // The LSB lane shows 1,1,0,0,0,0,0,0 which reassembles LSB-first to 8'h03.
        checks++;
        if (bytes_l.size() == 0 || bytes_l[$] !== 8'h03 || bytes_m[$] !== 8'h03) begin
            errors++;
            $display("FAIL lsb_first got=%02h (msb lane %02h) want=03",
                     bytes_l.size() ? bytes_l[$] : 8'hxx, bytes_m.size() ? bytes_m[$] : 8'hxx);
        end
    endtask

    task automatic test_random();
        logic [7:0] sent[$];
        logic [7:0] got[$];
        logic [7:0] b;
        clear_rx();
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                validIn = 1'b0;
                repeat ($urandom_range(1, 12)) begin
                    enb = ($urandom_range(0, 3) != 0);
                    tick();
                end
                enb = 1'b1;
            end
            b = 8'($urandom);
            send_one(b, 1'b1);
            sent.push_back(b);
        end
        idle(8);
        for (int i = 0; i < bytes_m.size(); i++) if (acked[i]) got.push_back(bytes_m[i]);
        checks++;
        if (got.size() != sent.size()) begin
            errors++;
            $display("FAIL random_count got=%0d want=%0d", got.size(), sent.size());
        end
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
                errors++;
                $display("FAIL random_byte%0d got=%02h want=%02h", i, got[i], sent[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_data();
        test_back_to_back();
        test_underrun();
        test_enb_stall();
        test_reset_mid();
        test_lsb_first();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
